// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM state encoding,
// SPI mode encodings ({cpol,cpha}) and the port-width helper.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEAD  = 2'd1,
    XFER  = 2'd2,
    TRAIL = 2'd3
  } spi_state_e;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Bits needed to encode 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// SCLK timing generator: a DIV-cycle phase counter plus an SCLK edge counter.
// tick_o marks the end of every DIV-cycle phase (lead, each SCLK edge, trail);
// lead_stb_o / trail_stb_o mark the leading / trailing SCLK edges of a frame
// and xfer_last_o flags the final edge (index 2*len-1).
module spi_edge_gen
  import spi_pkg::*;
#(
  parameter  int DIV    = 2,
  parameter  int LEN_W  = 9,
  localparam int CNT_W  = clog2_min1(DIV),
  localparam int EDGE_W = LEN_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             xfer_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             tick_o,
  output logic             lead_stb_o,
  output logic             trail_stb_o,
  output logic             xfer_last_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic [EDGE_W-1:0] last_idx;

  assign tick_o      = en_i && (cnt_q == CNT_W'(DIV - 1));
  assign lead_stb_o  = tick_o && xfer_i && !edge_q[0];
  assign trail_stb_o = tick_o && xfer_i &&  edge_q[0];
  assign last_idx    = {len_i, 1'b0} - EDGE_W'(1);
  assign xfer_last_o = xfer_i && (edge_q == last_idx);

  // Next phase/edge count: both clear while the master is idle.
  always_comb begin
    cnt_d  = cnt_q;
    edge_d = edge_q;
    if (!en_i) begin
      cnt_d  = '0;
      edge_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
      if (xfer_i) edge_d = edge_q + EDGE_W'(1);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_main_param.sv
// Parametrised SPI master for the AES link: IDLE -> LEAD -> XFER -> TRAIL.
// Runtime CPOL/CPHA and frame length, NUM_SLAVES chip selects, one-cycle err
// pulse on rejected requests. Frames go out MSB-first (bit len-1 first).
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that makes
// the sampling edge capture the current mosi instead of miso[sel].
module spi_main_param
  import spi_pkg::*;
#(
  parameter  int NUM_SLAVES = 2,
  parameter  int FRAME_W    = 258,
  parameter  int RX_W       = 128,
  parameter  int DIV        = 2,
  localparam int SEL_W      = clog2_min1(NUM_SLAVES),
  localparam int LEN_W      = clog2_min1(FRAME_W + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_W-1:0]      sel,
  input  logic [LEN_W-1:0]      len,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [FRAME_W-1:0]    tx_data,
  input  logic [NUM_SLAVES-1:0] miso,
`ifdef SPI_LOOPBACK_EN
  input  logic                  loopback,
`endif
  output logic [RX_W-1:0]       rx_data,
  output logic [NUM_SLAVES-1:0] cs_n,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  spi_state_e state_q, state_d;

  logic [NUM_SLAVES-1:0] cs_n_q, cs_n_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  sclk_q, mosi_q;
  logic [RX_W-1:0]       rx_q;
  logic                  cpol_q, cpha_q;
  logic [SEL_W-1:0]      sel_q;
  logic [LEN_W-1:0]      len_q;
  logic [FRAME_W-1:0]    sh_q;

  logic sel_ok, len_ok, accept, reject;
  logic tick, lead_stb, trail_stb, xfer_last;
  logic shift_edge, sample_edge, sample_bit;
  logic [LEN_W-1:0]   shamt;
  logic [FRAME_W-1:0] aligned;

  // Range checks only where the port width can exceed the legal range.
  if ((1 << SEL_W) > NUM_SLAVES) begin : g_sel_chk
    assign sel_ok = (sel < SEL_W'(NUM_SLAVES));
  end else begin : g_sel_full
    assign sel_ok = 1'b1;
  end

  if ((1 << LEN_W) > (FRAME_W + 1)) begin : g_len_chk
    assign len_ok = (len != '0) && (len <= LEN_W'(FRAME_W));
  end else begin : g_len_full
    assign len_ok = (len != '0);
  end

  assign accept = (state_q == IDLE) && start && sel_ok && len_ok;
  assign reject = (state_q == IDLE) && start && !(sel_ok && len_ok);

  // Left-justify the frame so the first bit to send is always the MSB.
  assign shamt   = LEN_W'(FRAME_W) - len;
  assign aligned = tx_data << shamt;

  spi_edge_gen #(
    .DIV   (DIV),
    .LEN_W (LEN_W)
  ) u_edge_gen (
    .clk         (clk),
    .rst         (rst),
    .en_i        (state_q != IDLE),
    .xfer_i      (state_q == XFER),
    .len_i       (len_q),
    .tick_o      (tick),
    .lead_stb_o  (lead_stb),
    .trail_stb_o (trail_stb),
    .xfer_last_o (xfer_last)
  );

  // CPHA=0 shifts on trailing edges (none after the final one); CPHA=1 on leading.
  assign shift_edge = cpha_q ? lead_stb : (trail_stb && !xfer_last);

`ifdef SPI_LOOPBACK_EN
  assign sample_bit = loopback ? mosi_q : miso[sel_q];
`else
  assign sample_bit = miso[sel_q];
`endif

  // Pick the sampling edge from the latched mode.
  always_comb begin
    sample_edge = 1'b0;
    case ({cpol_q, cpha_q})
      MODE0, MODE2: sample_edge = lead_stb;
      MODE1, MODE3: sample_edge = trail_stb;
      default:      sample_edge = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LEAD;
      LEAD:    if (tick) state_d = XFER;
      XFER:    if (trail_stb && xfer_last) state_d = TRAIL;
      TRAIL:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and chip-select outputs for the next cycle.
  always_comb begin
    cs_n_d = cs_n_q;
    busy_d = busy_q;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cs_n_d = ~(NUM_SLAVES'(1) << sel);
          busy_d = 1'b1;
        end else if (reject) begin
          err_d = 1'b1;
        end
      end
      TRAIL: begin
        if (tick) begin
          cs_n_d = '1;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered handshake/select outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cs_n_q <= cs_n_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // SCLK, MOSI, receive shift and latched mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      rx_q   <= '0;
      cpol_q <= 1'b0;
      cpha_q <= 1'b0;
    end else if (accept) begin
      cpol_q <= cpol;
      cpha_q <= cpha;
      sclk_q <= cpol;
      if (!cpha) mosi_q <= aligned[FRAME_W-1];
    end else begin
      if (lead_stb || trail_stb) sclk_q <= ~sclk_q;
      if (shift_edge) mosi_q <= sh_q[FRAME_W-1];
      if (sample_edge) rx_q <= {rx_q[RX_W-2:0], sample_bit};
    end
  end

  // Frame capture; with CPHA=0 the first bit is already on mosi at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      sel_q <= sel;
      len_q <= len;
      sh_q  <= cpha ? aligned : (aligned << 1);
    end else if (shift_edge) begin
      sh_q <= sh_q << 1;
    end
  end

  assign rx_data = rx_q;
  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
